mem_port_arbiter: RTL

//  Shares the single unified memory port of the multicycle MIPS core between the

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared fetch/data memory port of the multicycle core.
// Build option: define ARB_ROUND_ROBIN_EN for alternating tie-break (default: data wins ties).
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant_id
);
   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, if_rdata_q, d_rdata_q;
   logic              we_q, gid_q, en_q, if_ack_q, d_ack_q;
   logic              win_d;
   logic              grant;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_q;
   always_comb begin
      win_d = d_req;
      if (if_req && d_req) win_d = ~last_grant_q;
   end
`else
   always_comb begin
      win_d = d_req;
   end
`endif

   // DONE also arbitrates so a waiting requester is granted right after the ack cycle
   assign grant = ((state_q == IDLE) || (state_q == DONE)) && (if_req || d_req);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         gid_q      <= 1'b0;
         en_q       <= 1'b0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= 1'b0;
`endif
      end else begin
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               en_q <= 1'b0;
               if (grant) begin
                  state_q <= ACCESS;
                  en_q    <= 1'b1;
                  cnt_q   <= '0;
                  gid_q   <= win_d;
                  addr_q  <= win_d ? d_addr : if_addr;
                  we_q    <= win_d & d_we;
                  wdata_q <= win_d ? d_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
                  last_grant_q <= win_d;
`endif
               end else begin
                  state_q <= IDLE;
               end
            end
            ACCESS: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= DONE;
                  en_q    <= 1'b0;
                  if (!gid_q)     if_rdata_q <= mem_rdata;
                  else if (!we_q) d_rdata_q  <= mem_rdata;
                  if_ack_q <= ~gid_q;
                  d_ack_q  <= gid_q;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               en_q    <= 1'b0;
            end
         endcase
      end
   end

   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_ack    = if_ack_q;
   assign d_ack     = d_ack_q;
   assign mem_en    = en_q;
   assign mem_we    = en_q & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state_q != IDLE);
   assign grant_id  = gid_q;

endmodule
